// File: rtl/cond_flag_unit.sv
// cond_flag_unit: consumer end of the ALU result/flag interface.
// Holds the architectural NZCV register, evaluates the condition field of the
// instruction in execute against it and gates the write/PC strobes into the
// registered execute-to-memory boundary.
// Optional macro COND_PERF_EN adds saturating executed/skipped counters;
// without it exec_cnt_o and skip_cnt_o are tied to zero.
module cond_flag_unit #(
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             valid_i,
   input  logic [3:0]       cond_i,
   input  logic [1:0]       flag_wr_i,
   input  logic [3:0]       alu_flags_i,
   input  logic             reg_wr_i,
   input  logic             mem_wr_i,
   input  logic             pc_src_i,
   input  logic             stall_i,
   input  logic             flush_i,
   output logic [3:0]       flags_o,
   output logic             cond_pass_o,
   output logic             reg_wr_o,
   output logic             mem_wr_o,
   output logic             pc_src_o,
   output logic [CNT_W-1:0] exec_cnt_o,
   output logic [CNT_W-1:0] skip_cnt_o
);

   // Boundary register bundle
   typedef struct packed {
      logic cond_pass;
      logic reg_wr;
      logic mem_wr;
      logic pc_src;
   } bnd_t;

   logic [3:0] flags_q, flags_d;
   bnd_t       bnd_q, bnd_d;
   logic       pass;
   logic       accept;
   logic       n_f, z_f, c_f, v_f;

   assign n_f    = flags_q[3];
   assign z_f    = flags_q[2];
   assign c_f    = flags_q[1];
   assign v_f    = flags_q[0];
   assign accept = valid_i & ~stall_i & ~flush_i;

   // Condition evaluation against the architectural (pre-update) flags
   always_comb begin
      pass = 1'b0;
      unique case (cond_i)
         4'b0000: pass = z_f;
         4'b0001: pass = ~z_f;
         4'b0010: pass = c_f;
         4'b0011: pass = ~c_f;
         4'b0100: pass = n_f;
         4'b0101: pass = ~n_f;
         4'b0110: pass = v_f;
         4'b0111: pass = ~v_f;
         4'b1000: pass = c_f & ~z_f;
         4'b1001: pass = ~c_f | z_f;
         4'b1010: pass = (n_f == v_f);
         4'b1011: pass = (n_f != v_f);
         4'b1100: pass = ~z_f & (n_f == v_f);
         4'b1101: pass = z_f | (n_f != v_f);
         4'b1110: pass = 1'b1;
         default: pass = 1'b0;   // NV: reserved, never executes
      endcase
   end

   // Next flag value: only an accepted, passing instruction writes selected fields
   always_comb begin
      flags_d = flags_q;
      if (accept && pass) begin
         if (flag_wr_i[1]) flags_d[3:2] = alu_flags_i[3:2];
         if (flag_wr_i[0]) flags_d[1:0] = alu_flags_i[1:0];
      end
   end

   // Next boundary value: flush beats stall beats normal load
   always_comb begin
      bnd_d = bnd_q;
      if (flush_i) begin
         bnd_d = '0;
      end else if (!stall_i) begin
         bnd_d.cond_pass = valid_i & pass;
         bnd_d.reg_wr    = valid_i & pass & reg_wr_i;
         bnd_d.mem_wr    = valid_i & pass & mem_wr_i;
         bnd_d.pc_src    = valid_i & pass & pc_src_i;
      end
   end

   // Flag and boundary state
   always_ff @(posedge clk) begin
      if (rst) begin
         flags_q <= 4'b0000;
         bnd_q   <= '0;
      end else begin
         flags_q <= flags_d;
         bnd_q   <= bnd_d;
      end
   end

   assign flags_o     = flags_q;
   assign cond_pass_o = bnd_q.cond_pass;
   assign reg_wr_o    = bnd_q.reg_wr;
   assign mem_wr_o    = bnd_q.mem_wr;
   assign pc_src_o    = bnd_q.pc_src;

`ifdef COND_PERF_EN
   logic [CNT_W-1:0] exec_cnt_q, exec_cnt_d;
   logic [CNT_W-1:0] skip_cnt_q, skip_cnt_d;

   // Saturating counts of executed and condition-failed instructions
   always_comb begin
      exec_cnt_d = exec_cnt_q;
      skip_cnt_d = skip_cnt_q;
      if (accept && pass && (exec_cnt_q != {CNT_W{1'b1}}))
         exec_cnt_d = exec_cnt_q + 1'b1;
      if (accept && !pass && (skip_cnt_q != {CNT_W{1'b1}}))
         skip_cnt_d = skip_cnt_q + 1'b1;
   end

   // Counter state
   always_ff @(posedge clk) begin
      if (rst) begin
         exec_cnt_q <= '0;
         skip_cnt_q <= '0;
      end else begin
         exec_cnt_q <= exec_cnt_d;
         skip_cnt_q <= skip_cnt_d;
      end
   end

   assign exec_cnt_o = exec_cnt_q;
   assign skip_cnt_o = skip_cnt_q;
`else
   assign exec_cnt_o = '0;
   assign skip_cnt_o = '0;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit with hand-computed expectations.
module tb_cond_flag_unit;
   localparam int CNT_W = 4;

   logic             clk = 1'b0;
   logic             rst;
   logic             valid_i;
   logic [3:0]       cond_i;
   logic [1:0]       flag_wr_i;
   logic [3:0]       alu_flags_i;
   logic             reg_wr_i, mem_wr_i, pc_src_i;
   logic             stall_i, flush_i;
   logic [3:0]       flags_o;
   logic             cond_pass_o, reg_wr_o, mem_wr_o, pc_src_o;
   logic [CNT_W-1:0] exec_cnt_o, skip_cnt_o;

   int errors = 0;
   int checks = 0;

   cond_flag_unit #(.CNT_W(CNT_W)) dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .cond_i(cond_i),
      .flag_wr_i(flag_wr_i), .alu_flags_i(alu_flags_i),
      .reg_wr_i(reg_wr_i), .mem_wr_i(mem_wr_i), .pc_src_i(pc_src_i),
      .stall_i(stall_i), .flush_i(flush_i), .flags_o(flags_o),
      .cond_pass_o(cond_pass_o), .reg_wr_o(reg_wr_o), .mem_wr_o(mem_wr_o),
      .pc_src_o(pc_src_o), .exec_cnt_o(exec_cnt_o), .skip_cnt_o(skip_cnt_o)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   // Advance one clock, sample 1 time unit after the edge
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [3:0] c, input logic [1:0] fw,
                        input logic [3:0] af, input logic rw, input logic mw, input logic ps);
      valid_i = v; cond_i = c; flag_wr_i = fw; alu_flags_i = af;
      reg_wr_i = rw; mem_wr_i = mw; pc_src_i = ps;
   endtask

   logic [15:0] exp_tbl;
   logic [CNT_W-1:0] exp_exec, exp_skip;

   initial begin
      rst = 1'b1; stall_i = 1'b0; flush_i = 1'b0;
      drive(1'b0, 4'h0, 2'b00, 4'h0, 1'b0, 1'b0, 1'b0);
      step(); step();
      chk("rst_flags", flags_o, 4'b0000);
      chk("rst_pass", cond_pass_o, 1'b0);
      chk("rst_reg_wr", reg_wr_o, 1'b0);
      chk("rst_mem_wr", mem_wr_o, 1'b0);
      chk("rst_pc_src", pc_src_o, 1'b0);
      chk("rst_exec", exec_cnt_o, 0);
      chk("rst_skip", skip_cnt_o, 0);
      rst = 1'b0;

      // AL with flag set
      drive(1'b1, 4'b1110, 2'b11, 4'b0100, 1'b1, 1'b0, 1'b0);
      step();
      chk("al_reg_wr", reg_wr_o, 1'b1);
      chk("al_pass", cond_pass_o, 1'b1);
      chk("al_flags", flags_o, 4'b0100);

      // NE fails on Z=1; flags must not change
      drive(1'b1, 4'b0001, 2'b11, 4'b1000, 1'b0, 1'b1, 1'b0);
      step();
      chk("ne_mem_wr", mem_wr_o, 1'b0);
      chk("ne_pass", cond_pass_o, 1'b0);
      chk("ne_flags", flags_o, 4'b0100);

      // EQ passes
      drive(1'b1, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b1);
      step();
      chk("eq_pc_src", pc_src_o, 1'b1);
      chk("eq_pass", cond_pass_o, 1'b1);

      // Partial updates
      drive(1'b1, 4'b1110, 2'b11, 4'b0011, 1'b0, 1'b0, 1'b0);
      step();
      chk("part_setup", flags_o, 4'b0011);
      drive(1'b1, 4'b1110, 2'b10, 4'b1100, 1'b0, 1'b0, 1'b0);
      step();
      chk("part_nz", flags_o, 4'b1111);
      drive(1'b1, 4'b1110, 2'b01, 4'b0000, 1'b0, 1'b0, 1'b0);
      step();
      chk("part_cv", flags_o, 4'b1100);

      // Signed: N=1 V=0 Z=0
      drive(1'b1, 4'b1110, 2'b11, 4'b1000, 1'b0, 1'b0, 1'b0);
      step();
      chk("sgn_setup1", flags_o, 4'b1000);
      drive(1'b1, 4'b1100, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0); step();
      chk("gt_nv10", cond_pass_o, 1'b0);
      drive(1'b1, 4'b1011, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0); step();
      chk("lt_nv10", cond_pass_o, 1'b1);
      drive(1'b1, 4'b1101, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0); step();
      chk("le_nv10", cond_pass_o, 1'b1);

      // Signed: N=1 V=1 Z=0 C=0
      drive(1'b1, 4'b1110, 2'b11, 4'b1001, 1'b0, 1'b0, 1'b0);
      step();
      chk("sgn_setup2", flags_o, 4'b1001);
      // Full condition table against NZCV=1001
      exp_tbl = 16'h565A;
      for (int i = 0; i < 16; i++) begin
         drive(1'b1, 4'(i), 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
         step();
         chk($sformatf("cond_tbl_%0d", i), cond_pass_o, exp_tbl[i]);
      end
      chk("tbl_flags_hold", flags_o, 4'b1001);

      // HI/LS with C=1 Z=0; first instruction also checks back-to-back flag use
      drive(1'b1, 4'b1110, 2'b11, 4'b0010, 1'b0, 1'b0, 1'b0); step();
      drive(1'b1, 4'b1000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0); step();
      chk("hi_c1z0", cond_pass_o, 1'b1);
      drive(1'b1, 4'b1001, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0); step();
      chk("ls_c1z0", cond_pass_o, 1'b0);

      // Stall holds boundary and flags
      drive(1'b1, 4'b1110, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0); step();
      chk("pre_stall_reg_wr", reg_wr_o, 1'b1);
      stall_i = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive(1'b1, 4'(14 - i), 2'b11, 4'(4'hF - i), 1'b0, 1'b1, 1'b1);
         step();
         chk($sformatf("stall_reg_wr_%0d", i), reg_wr_o, 1'b1);
         chk($sformatf("stall_flags_%0d", i), flags_o, 4'b0010);
      end
      flush_i = 1'b1;
      step();
      chk("flush_reg_wr", reg_wr_o, 1'b0);
      chk("flush_pc_src", pc_src_o, 1'b0);
      chk("flush_flags", flags_o, 4'b0010);
      stall_i = 1'b0; flush_i = 1'b0;

      // Idle cycle loads zeros
      drive(1'b1, 4'b1110, 2'b00, 4'b0000, 1'b1, 1'b0, 1'b0); step();
      drive(1'b0, 4'b1110, 2'b11, 4'b1111, 1'b1, 1'b0, 1'b0); step();
      chk("idle_reg_wr", reg_wr_o, 1'b0);
      chk("idle_pass", cond_pass_o, 1'b0);
      chk("idle_flags", flags_o, 4'b0010);

      // Reset mid-stream wins
      rst = 1'b1;
      drive(1'b1, 4'b1110, 2'b11, 4'b1111, 1'b1, 1'b1, 1'b1); step();
      chk("midrst_flags", flags_o, 4'b0000);
      chk("midrst_reg_wr", reg_wr_o, 1'b0);
      chk("midrst_exec", exec_cnt_o, 0);
      rst = 1'b0;

      // Performance counters: 20 AL then 3 NV
      drive(1'b1, 4'b1110, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 20; i++) step();
      drive(1'b1, 4'b1111, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
      for (int i = 0; i < 3; i++) step();
      drive(1'b0, 4'b0000, 2'b00, 4'b0000, 1'b0, 1'b0, 1'b0);
      step();
`ifdef COND_PERF_EN
      exp_exec = 4'd15; exp_skip = 4'd3;
`else
      exp_exec = 4'd0;  exp_skip = 4'd0;
`endif
      chk("exec_cnt", exec_cnt_o, exp_exec);
      chk("skip_cnt", skip_cnt_o, exp_skip);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
